ldpc_encoder_top: RTL and testbench

- Systematic/generic linear block encoder for the LDPC datapath.
- Multiplies a K-bit information word by a runtime-supplied K×N generator matrix over GF(2).
- Registers the resulting N-bit codeword.
- Sits between the info-bit source and the channel/modulator stage. The generator is supplied as a flat bus so the matrix can be swapped without re-synthesis.

---
 rtl/ldpc_pkg.sv | 15 +
 rtl/ldpc_encoder_gf2_vec_mat_mul.sv | 20 ++
 rtl/ldpc_encoder_top.sv | 33 +++
 tb/tb_ldpc_encoder_top.sv | 116 +++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared LDPC constants and GF(2) helpers for the encoder and future decoder.
package ldpc_pkg;
  localparam int N_DEF = 11;
  localparam int K_DEF = 6;
  localparam int MAX_W = 64;

  function automatic int row_off(input int r, input int n, input int k);
    return (k - 1 - r) * n;
  endfunction

  // Operands are zero-extended by callers, so the high bits never contribute.
  function automatic logic gf2_dot(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b);
    return ^(a & b);
  endfunction
endpackage

// File: rtl/ldpc_encoder_gf2_vec_mat_mul.sv
// gf2_vec_mat_mul: combinational K-bit vector by KxN matrix product over GF(2).
module gf2_vec_mat_mul
  import ldpc_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int K = K_DEF
) (
  input  logic [K-1:0]   info_bits,
  input  logic [K*N-1:0] generator,
  output logic [N-1:0]   product
);
  for (genvar c = 0; c < N; c++) begin : g_col
    logic [K-1:0] col;
    // col is aligned with info_bits: col[K-1-r] is G[r][c]
    for (genvar r = 0; r < K; r++) begin : g_row
      assign col[K-1-r] = generator[row_off(r, N, K) + N - 1 - c];
    end
    assign product[N-1-c] = gf2_dot(MAX_W'(info_bits), MAX_W'(col));
  end
endmodule

// File: rtl/ldpc_encoder_top.sv
// ldpc_encoder_top: registered GF(2) block encoder with a runtime generator matrix.
module ldpc_encoder_top
  import ldpc_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int K = K_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_en,
  input  logic [K-1:0]   info_bits,
  input  logic [K*N-1:0] generator,
  output logic [N-1:0]   codeword,
  output logic           o_valid
);
  logic [N-1:0] product;

  gf2_vec_mat_mul #(.N(N), .K(K)) u_mul (
    .info_bits(info_bits),
    .generator(generator),
    .product(product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      codeword <= '0;
      o_valid  <= 1'b0;
    end else begin
      o_valid <= i_en;
      if (i_en) codeword <= product;
    end
  end
endmodule

// File: tb/tb_ldpc_encoder_top.sv
// tb_ldpc_encoder_top: directed vectors with hand-computed codewords for N=11, K=6.
module tb_ldpc_encoder_top;
  localparam int N = 11;
  localparam int K = 6;
  localparam logic [K*N-1:0] G = {11'b10000010000, 11'b01000001000, 11'b00100000100,
                                  11'b00010000010, 11'b00001000001, 11'b00000111111};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_en = 1'b0;
  logic [K-1:0] info_bits = '0;
  logic [K*N-1:0] generator = G;
  logic [N-1:0] codeword;
  logic o_valid;
  int passed = 0;
  int total = 0;

  ldpc_encoder_top #(.N(N), .K(K)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_en(i_en),
    .info_bits(info_bits),
    .generator(generator),
    .codeword(codeword),
    .o_valid(o_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    edge1();
    i_en = 1'b1;
    info_bits = 6'b111111;
    edge1();
    chk("rst_cw", codeword, 11'b0);
    chk("rst_valid", N'(o_valid), 11'd0);
    @(negedge clk);
    rst_n = 1'b1;
    i_en = 1'b0;
    edge1();
    chk("idle_valid", N'(o_valid), 11'd0);

    i_en = 1'b1;
    info_bits = 6'b111111;
    edge1();
    chk("full_cw", codeword, 11'b11111100000);
    chk("full_valid", N'(o_valid), 11'd1);
    i_en = 1'b0;
    edge1();
    chk("full_hold_cw", codeword, 11'b11111100000);
    chk("full_hold_valid", N'(o_valid), 11'd0);

    i_en = 1'b1;
    info_bits = 6'b100000;
    edge1();
    chk("row0_cw", codeword, 11'b10000010000);
    info_bits = 6'b000001;
    edge1();
    chk("row5_cw", codeword, 11'b00000111111);

    i_en = 1'b0;
    info_bits = 6'b010101;
    edge1();
    chk("hold_cw", codeword, 11'b00000111111);
    chk("hold_valid", N'(o_valid), 11'd0);
    i_en = 1'b1;
    edge1();
    chk("rows135_cw", codeword, 11'b01010110101);

    info_bits = 6'b000000;
    edge1();
    chk("stream0_cw", codeword, 11'b0);
    chk("stream0_valid", N'(o_valid), 11'd1);
    info_bits = 6'b100000;
    edge1();
    chk("stream1_cw", codeword, 11'b10000010000);
    chk("stream1_valid", N'(o_valid), 11'd1);
    info_bits = 6'b111111;
    edge1();
    chk("stream2_cw", codeword, 11'b11111100000);
    chk("stream2_valid", N'(o_valid), 11'd1);

    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cw", codeword, 11'b0);
    chk("async_rst_valid", N'(o_valid), 11'd0);
    edge1();
    chk("rst_hold_cw", codeword, 11'b0);
    @(negedge clk);
    rst_n = 1'b1;
    info_bits = 6'b000001;
    edge1();
    chk("post_rst_cw", codeword, 11'b00000111111);
    generator = '0;
    info_bits = 6'b111111;
    edge1();
    chk("zero_gen_cw", codeword, 11'b0);
    chk("zero_gen_valid", N'(o_valid), 11'd1);
    i_en = 1'b0;
    edge1();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
